// File: rtl/miri_pkg.sv
// Shared definitions for the MIRI core: datapath widths, the instruction
// encoding, and the instruction-cache controller state type.
package miri_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LINE_BITS = 128;
    localparam int unsigned WORDS     = LINE_BITS / WORD_W;

    // The all-zero word doubles as the pipeline bubble.
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;

    // Primary opcodes.
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_LDB = 4'h3;
    localparam logic [3:0] OP_LDW = 4'h4;
    localparam logic [3:0] OP_STB = 4'h5;
    localparam logic [3:0] OP_STW = 4'h6;
    localparam logic [3:0] OP_BEQ = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } icache_state_t;

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag storage for a direct-mapped cache.
// Read is combinational, write is synchronous. Only the valid bits are reset.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rd_idx            lookup line index
//   rd_valid, rd_tag  valid bit and stored tag of line rd_idx
//   wr_en             write wr_tag into line wr_idx and mark it valid
//   wr_idx, wr_tag    write line index and tag
//   clr_all           invalidate every line (wins over wr_en)
module icache_tag_array #(
    parameter int unsigned LINES = 4,
    parameter int unsigned TAG_W = 26,
    localparam int unsigned IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clr_all
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with a req/ack line-refill controller.
// A hit returns the instruction in the same cycle; a miss stalls the core
// (iCacheMiss=1) while one 128-bit line is fetched from memory.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc, pc_valid        fetch byte address and fetch request
//   flush               invalidate all lines
//   instr, iCacheMiss   fetched word, stall indication
//   mem_req, mem_addr   line refill request and line-aligned address
//   mem_ack, mem_rdata  refill acknowledge and line data
//   hit_cnt, miss_cnt   saturating hit/miss counters (only with ICACHE_STATS_EN)
// Optional feature: define ICACHE_STATS_EN to add the hit/miss counters.
module icache_ctrl
    import miri_pkg::*;
#(
    parameter int unsigned LINES  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    pc,
    input  logic                 pc_valid,
    input  logic                 flush,
    output logic [WORD_W-1:0]    instr,
    output logic                 iCacheMiss,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [LINE_BITS-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - 4 - IDX_W;

    icache_state_t     state_q, state_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic              flush_pend_q, flush_pend_d;

    logic [IDX_W-1:0]  idx, fill_idx;
    logic [TAG_W-1:0]  tag, fill_tag;
    logic [1:0]        word;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic              lookup_hit;
    logic              fill_we;
    logic              clr_all;
    logic              unused_pc;

    logic [LINE_BITS-1:0]         data_q [LINES];
    logic [WORDS-1:0][WORD_W-1:0] line_words;

    assign idx       = pc[4 +: IDX_W];
    assign tag       = pc[ADDR_W-1 -: TAG_W];
    assign word      = pc[3:2];
    assign unused_pc = ^pc[1:0];
    assign fill_idx  = miss_addr_q[4 +: IDX_W];
    assign fill_tag  = miss_addr_q[ADDR_W-1 -: TAG_W];

    icache_tag_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .wr_en    (fill_we),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .clr_all  (clr_all)
    );

    assign lookup_hit = pc_valid & rd_valid & (rd_tag == tag);
    assign line_words = data_q[idx];

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        instr        = NOP_INSTR;
        iCacheMiss   = 1'b1;
        mem_req      = 1'b0;
        fill_we      = 1'b0;
        clr_all      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Lookup sees the pre-flush valid bits; the clear lands at the edge.
                clr_all = flush;
                if (!pc_valid) begin
                    iCacheMiss = 1'b0;
                end else if (lookup_hit) begin
                    iCacheMiss = 1'b0;
                    instr      = line_words[word];
                end else begin
                    miss_addr_d = {pc[ADDR_W-1:4], 4'b0};
                    state_d     = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    fill_we = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                // A flush seen during the refill also kills the line just filled.
                clr_all      = flush_pend_q | flush;
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!rst_n) begin
            instr      = NOP_INSTR;
            iCacheMiss = 1'b1;
        end
    end

    assign mem_addr = miss_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        hit_evt, miss_evt;

    assign hit_evt  = (state_q == IDLE) & lookup_hit;
    assign miss_evt = (state_q == IDLE) & (state_d == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl (LINES=4, ADDR_W=32).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_icache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  pc;
    logic         pc_valid;
    logic         flush;
    logic [31:0]  instr;
    logic         icache_miss;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [127:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_ctrl #(
        .LINES  (4),
        .ADDR_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .instr      (instr),
        .iCacheMiss (icache_miss),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word k of the line at address a, e.g. a=0 -> CAFE0000, CAFE0004, ...
    function automatic logic [31:0] word_of(input logic [31:0] a, input int k);
        return ({a[31:4], 4'b0} + 32'(k * 4)) ^ 32'hCAFE_0000;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[k*32 +: 32] = word_of(a, k);
        end
        return l;
    endfunction

    // Entered in the IDLE miss cycle (inputs set, outputs settled); returns at
    // the falling edge that starts the post-FILL IDLE cycle.
    task automatic refill(input logic [31:0] a, input int dly);
        check("miss_detect", 32'(icache_miss), 32'd1);
        check("miss_noreq", 32'(mem_req), 32'd0);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk); #1;
            check("req_wait", 32'(mem_req), 32'd1);
            check("req_addr_wait", mem_addr, a);
            check("req_stall", 32'(icache_miss), 32'd1);
        end
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = line_of(a);
        #1;
        check("req_ack", 32'(mem_req), 32'd1);
        check("req_addr", mem_addr, a);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        check("fill_stall", 32'(icache_miss), 32'd1);
        check("fill_noreq", 32'(mem_req), 32'd0);
        @(negedge clk);
    endtask

    task automatic expect_hit(input logic [31:0] a, input logic [31:0] line_a, input int k);
        pc = a;
        #1;
        check("hit_miss", 32'(icache_miss), 32'd0);
        check("hit_instr", instr, word_of(line_a, k));
        check("hit_noreq", 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        pc        = '0;
        pc_valid  = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        pc_valid = 1'b1;
        #1;
        check("rst_miss", 32'(icache_miss), 32'd1);
        check("rst_instr", instr, 32'h0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'h0);

        // Cold miss on 0x0, ack two cycles after the request appears.
        @(negedge clk);
        rst_n = 1'b1;
        pc    = 32'h0;
        #1;
        refill(32'h0, 2);
        for (int k = 0; k < 4; k++) begin
            expect_hit(32'(k * 4), 32'h0, k);
            @(negedge clk);
        end

        // Bubble.
        pc_valid = 1'b0;
        #1;
        check("bubble_miss", 32'(icache_miss), 32'd0);
        check("bubble_instr", instr, 32'h0);

        // Conflict on idx 0 with ack in the first REQ cycle (3-cycle penalty).
        @(negedge clk);
        pc_valid = 1'b1;
        pc       = 32'h40;
        #1;
        refill(32'h40, 0);
        expect_hit(32'h44, 32'h40, 1);
        @(negedge clk);
        pc = 32'h0;
        #1;
        refill(32'h0, 1);
        expect_hit(32'h8, 32'h0, 2);

        // Flush during REQ: the line filled for 0x100 is dropped.
        @(negedge clk);
        pc = 32'h100;
        #1;
        check("fl_req_miss", 32'(icache_miss), 32'd1);
        @(negedge clk);
        flush     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = line_of(32'h100);
        #1;
        check("fl_req_addr", mem_addr, 32'h100);
        @(negedge clk);
        flush     = 1'b0;
        mem_ack   = 1'b0;
        #1;
        check("fl_fill_stall", 32'(icache_miss), 32'd1);
        @(negedge clk);
        #1;
        refill(32'h100, 0);
        expect_hit(32'h108, 32'h100, 2);

        // Flush in IDLE: this cycle still hits, the next misses.
        @(negedge clk);
        pc    = 32'h100;
        flush = 1'b1;
        #1;
        check("fl_idle_hit", 32'(icache_miss), 32'd0);
        check("fl_idle_instr", instr, word_of(32'h100, 0));
        @(negedge clk);
        flush = 1'b0;
        #1;
        refill(32'h100, 1);

        // pc change during refill: 0x200 completes, then 0x10 is looked up.
        pc = 32'h200;
        #1;
        check("chg_miss", 32'(icache_miss), 32'd1);
        @(negedge clk);
        pc = 32'h10;
        #1;
        check("chg_addr", mem_addr, 32'h200);
        check("chg_stall", 32'(icache_miss), 32'd1);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = line_of(32'h200);
        @(negedge clk);
        mem_ack   = 1'b0;
        #1;
        check("chg_fill", 32'(icache_miss), 32'd1);
        @(negedge clk);
        #1;
        refill(32'h10, 0);
        expect_hit(32'h204, 32'h200, 1);
        expect_hit(32'h1C, 32'h10, 3);

        // Reset during REQ, then a late ack in IDLE.
        @(negedge clk);
        pc = 32'h300;
        #1;
        check("mid_miss", 32'(icache_miss), 32'd1);
        @(negedge clk);
        #1;
        check("mid_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_miss", 32'(icache_miss), 32'd1);
        check("mid_rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        pc_valid  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = line_of(32'h300);
        #1;
        check("late_ack_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        pc_valid  = 1'b1;
        #1;
        refill(32'h300, 0);
        expect_hit(32'h300, 32'h300, 0);
        @(negedge clk);
        expect_hit(32'h304, 32'h300, 1);
        @(negedge clk);
        expect_hit(32'h308, 32'h300, 2);

`ifdef ICACHE_STATS_EN
        @(negedge clk);
        pc_valid = 1'b0;
        #1;
        check("stat_hits", hit_cnt, 32'd3);
        check("stat_misses", miss_cnt, 32'd1);
        force dut.hit_cnt_q  = 32'hFFFF_FFFF;
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt_q;
        release dut.miss_cnt_q;
        pc_valid = 1'b1;
        pc       = 32'h300;
        @(negedge clk);
        pc = 32'h400;
        #1;
        check("stat_hit_sat", hit_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        check("stat_miss_sat", miss_cnt, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
